// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for a WIDTH-bit inverter: drives vectors, waits SETTLE cycles, checks ~gate_in.
// Build option: define GATE_SEQ_STOP_ON_FAIL_EN to end a run at the first mismatch.
module gate_test_sequencer #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [WIDTH-1:0] gate_in_o,
  input  logic [WIDTH-1:0] gate_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_o
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   gate_in_q, gate_in_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               fail_q, fail_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mismatch_s;
  logic [CNT_W-1:0]   idx_inc_s;

  function automatic logic vec_mismatch(input logic [WIDTH-1:0] drv,
                                        input logic [WIDTH-1:0] obs);
    return (obs != ~drv);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gate_in_q <= {WIDTH{1'b0}};
      idx_q     <= {CNT_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      err_q     <= {CNT_W{1'b0}};
      fail_q    <= 1'b0;
      wait_q    <= {WAIT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_in_q <= gate_in_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    gate_in_d  = gate_in_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_d     = fail_q;
    wait_d     = wait_q;
    mismatch_s = vec_mismatch(gate_in_q, gate_out_i);
    idx_inc_s  = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d  = {CNT_W{1'b0}};
          fail_d = 1'b0;
          if (num_vec_i != {CNT_W{1'b0}}) begin
            cnt_d   = num_vec_i;
            idx_d   = {CNT_W{1'b0}};
            state_d = S_DRIVE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        // Vector is the low WIDTH bits of the index, so it wraps naturally
        gate_in_d = WIDTH'(idx_q);
        wait_d    = {WAIT_W{1'b0}};
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
          state_d = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch_s) begin
          err_d  = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
          fail_d = 1'b1;
        end else begin
          err_d  = err_q;
          fail_d = fail_q;
        end
        idx_d = idx_inc_s;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        if (mismatch_s || (idx_inc_s == cnt_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
`else
        if (idx_inc_s == cnt_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
`endif
      end
      S_DONE: begin
        gate_in_d = {WIDTH{1'b0}};
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign gate_in_o = gate_in_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_cnt_o = err_q;
  assign fail_o    = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: WIDTH=1 and WIDTH=2 instances with behavioural gate models.
module tb_gate_test_sequencer;

  logic       clk;
  int         checks;
  int         errors;

  logic       rst1, start1, g_in1, g_out1, busy1, done1, fail1, inv1_q, stuck1;
  logic [7:0] nv1, err1;

  logic       rst2, start2, busy2, done2, fail2, buf2;
  logic [1:0] g_in2, g_out2;
  logic [7:0] nv2, err2;

  int         pulses;
  int         first_edge;

  gate_test_sequencer #(.WIDTH(1), .SETTLE(2), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .start_i(start1), .num_vec_i(nv1),
    .gate_in_o(g_in1), .gate_out_i(g_out1), .busy_o(busy1), .done_o(done1),
    .err_cnt_o(err1), .fail_o(fail1)
  );

  gate_test_sequencer #(.WIDTH(2), .SETTLE(2), .CNT_W(8)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .num_vec_i(nv2),
    .gate_in_o(g_in2), .gate_out_i(g_out2), .busy_o(busy2), .done_o(done2),
    .err_cnt_o(err2), .fail_o(fail2)
  );

  // Registered ideal inverter (or stuck-at-0) for the 1-bit instance
  always @(posedge clk) inv1_q <= ~g_in1;
  assign g_out1 = stuck1 ? 1'b0 : inv1_q;
  // Combinational buffer (faulty) or inverter (good) for the 2-bit instance
  assign g_out2 = buf2 ? g_in2 : ~g_in2;

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0; checks = 0; errors = 0;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    nv1 = 8'd0; nv2 = 8'd0; stuck1 = 1'b0; buf2 = 1'b1;

    // Reset state
    #2;
    check("rst_gate_in", g_in1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_err", err1, 0);
    check("rst_fail", fail1, 0);
    tick(2);
    rst1 = 1'b0; rst2 = 1'b0;
    tick(1);

    // Ideal inverter, 4 vectors: gate_in 0,1,0,1, done at edge 16
    start1 = 1'b1; nv1 = 8'd4;
    tick(1);
    start1 = 1'b0; nv1 = 8'd0;
    check("t1_busy_e0", busy1, 1);
    check("t1_done_e0", done1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("t1_gate_in", g_in1, k % 2);
      tick(3);
      if (k < 3) check("t1_busy", busy1, 1);
    end
    check("t1_done", done1, 1);
    check("t1_busy_end", busy1, 0);
    check("t1_err", err1, 0);
    check("t1_fail", fail1, 0);
    tick(1);
    check("t1_done_off", done1, 0);
    check("t1_gate_in_clr", g_in1, 0);
    tick(1);

    // Stuck-at-0 output: vectors 0 and 2 mismatch
    stuck1 = 1'b1;
    start1 = 1'b1; nv1 = 8'd4;
    tick(1);
    start1 = 1'b0;
    tick(4);
    check("t2_err_e4", err1, 1);
    check("t2_fail_e4", fail1, 1);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check("t2_done_e4", done1, 1);
    check("t2_busy_e4", busy1, 0);
    tick(1);
    check("t2_done_off", done1, 0);
`else
    check("t2_done_e4", done1, 0);
    tick(12);
    check("t2_done", done1, 1);
    check("t2_err", err1, 2);
    check("t2_fail", fail1, 1);
    tick(1);
`endif
    tick(1);

    // Zero-length run clears the previous fail
    start1 = 1'b1; nv1 = 8'd0;
    tick(1);
    start1 = 1'b0;
    check("t3_done", done1, 1);
    check("t3_busy", busy1, 0);
    check("t3_err", err1, 0);
    check("t3_fail", fail1, 0);
    tick(1);
    check("t3_done_off", done1, 0);
    check("t3_busy_off", busy1, 0);
    tick(1);

    // Start during SETTLE of vector 1 is ignored
    stuck1 = 1'b0;
    start1 = 1'b1; nv1 = 8'd3;
    tick(1);
    start1 = 1'b0;
    tick(5);
    start1 = 1'b1; nv1 = 8'd1;
    tick(1);
    start1 = 1'b0;
    pulses = 0; first_edge = 0;
    for (int e = 7; e <= 20; e++) begin
      tick(1);
      if (done1) begin
        pulses++;
        if (first_edge == 0) first_edge = e;
      end
    end
    check("t4_pulses", pulses, 1);
    check("t4_done_edge", first_edge, 12);
    check("t4_err", err1, 0);

    // WIDTH=2 buffer: every vector mismatches, vector wraps 0,1,2,3,0
    buf2 = 1'b1;
    start2 = 1'b1; nv2 = 8'd5;
    tick(1);
    start2 = 1'b0;
    tick(1);
    check("t5_gate_in_0", g_in2, 0);
    tick(3);
    check("t5_err_e4", err2, 1);
    check("t5_fail_e4", fail2, 1);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check("t5_done_e4", done2, 1);
    tick(1);
`else
    for (int k = 1; k < 5; k++) begin
      tick(1);
      check("t5_gate_in", g_in2, k % 4);
      tick(3);
    end
    check("t5_done", done2, 1);
    check("t5_err", err2, 5);
    check("t5_fail", fail2, 1);
    tick(1);
`endif
    tick(1);

    // Reset during SETTLE of vector 2
    start2 = 1'b1; nv2 = 8'd4;
    tick(1);
    start2 = 1'b0;
    tick(10);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check("t6_busy_pre", busy2, 0);
    check("t6_err_pre", err2, 1);
`else
    check("t6_gate_in_pre", g_in2, 2);
    check("t6_busy_pre", busy2, 1);
    check("t6_err_pre", err2, 2);
`endif
    #1 rst2 = 1'b1;
    #1;
    check("t6_gate_in_rst", g_in2, 0);
    check("t6_busy_rst", busy2, 0);
    check("t6_err_rst", err2, 0);
    check("t6_fail_rst", fail2, 0);
    check("t6_done_rst", done2, 0);
    tick(2);
    rst2 = 1'b0;
    pulses = 0;
    for (int e = 0; e < 6; e++) begin
      tick(1);
      if (done2) pulses++;
    end
    check("t6_no_done", pulses, 0);

    // Fresh run after reset, good inverter
    buf2 = 1'b0;
    start2 = 1'b1; nv2 = 8'd2;
    tick(1);
    start2 = 1'b0;
    tick(1);
    check("t7_gate_in_0", g_in2, 0);
    tick(4);
    check("t7_gate_in_1", g_in2, 1);
    tick(3);
    check("t7_done", done2, 1);
    check("t7_err", err2, 0);
    check("t7_fail", fail2, 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
